fetch_aligner: RTL and testbench
================================

# fetch_aligner

Instruction fetch and alignment stage that sits directly upstream of the instruction decoder. It issues word-aligned reads to instruction memory and reassembles 16-bit compressed and 32-bit instructions, including 32-bit instructions that straddle a word boundary. It presents one instruction and its PC at a time over a valid/ready handshake, and restarts from a new PC on a redirect from the execute stage.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch PC after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_valid`  out  1  read request to instruction memory.
- `mem_addr`  out  32  word address of the request; bits [1:0] are always 0.
- `mem_ready`  in  1  request accepted; `mem_rdata` is valid in this same cycle.
- `mem_rdata`  in  32  read data.
- `redirect`  in  1  restart fetch at `redirect_pc`; a one-cycle pulse.
- `redirect_pc`  in  32  new PC.
- `instr_valid`  out  1  output slot full.
- `instr_ready`  in  1  decoder accepts the slot.
- `instr`  out  32  instruction. Compressed instructions are zero-extended to `{16'b0, half}`.
- `pc`  out  32  PC of `instr`.
- `instr_fault`  out  1  misaligned-PC fault; qualified by `instr_valid`.

## Operation
- Internal state:
  - fetch PC `fpc`;
  - 16-bit `hold` register with `hold_valid`, holding the halfword at `fpc` when `fpc[1]`=1;
  - `squash` flag;
  - single output slot (`instr`, `pc`, `instr_fault`, `instr_valid`).
- FSM states:
  - FETCH: `mem_valid`=1, `mem_addr`=`{fpc[31:2],2'b00}`.
  - EMIT: waiting for the output slot to drain.
  - HALT: after a fault, wait for `redirect`.
- A new instruction is produced only when the slot is empty or is being consumed this cycle (`instr_valid && instr_ready`).
- Alignment cases on a memory response with data `w`, or on a hold-only step:
  - `fpc[1]`=0, `w[1:0]`=11: emit `w` at `fpc`; `fpc += 4`.
  - `fpc[1]`=0, `w[1:0]`!=11: emit `{16'b0,w[15:0]}` at `fpc`; `hold`=`w[31:16]`, `hold_valid`=1; `fpc += 2`.
  - `hold_valid`, `hold[1:0]`!=11: emit `{16'b0,hold}` at `fpc` with no memory access; clear `hold_valid`; `fpc += 2`.
  - `hold_valid`, `hold[1:0]`=11: fetch the next word, emit `{w[15:0],hold}` at `fpc`; `hold`=`w[31:16]`, `hold_valid` stays 1; `fpc += 4`.
  - `fpc[1]`=1, `!hold_valid` (only after a redirect): fetch, `hold`=`w[31:16]`, `hold_valid`=1, emit nothing.
- Redirect:
  - Has priority over every other event in the same cycle.
  - Clears the slot, so `instr_valid`=0 next cycle even if `instr_ready` was high.
  - Clears `hold_valid`, loads `fpc`=`redirect_pc`.
- Redirect while a request is outstanding (`mem_valid && !mem_ready`):
  - `mem_valid` and `mem_addr` stay unchanged until `mem_ready`.
  - `squash`=1; that response is discarded and a new request is issued the cycle after.
  - A further redirect while squashing just overwrites `fpc`; only the latest redirect target is used.
- Fault: `redirect_pc[0]`=1 emits `instr`=0, `pc`=`redirect_pc`, `instr_fault`=1, `instr_valid`=1, then enters HALT. No memory requests are made until the next redirect.

## Timing
- Reset values:
  - `mem_valid`=0, `mem_addr`=0;
  - `instr_valid`=0, `instr`=0, `pc`=`RESET_PC`, `instr_fault`=0;
  - `hold_valid`=0, `squash`=0, `fpc`=`RESET_PC`, state FETCH.
- First `mem_valid`=1 in the first cycle after `reset` deasserts.
- Reset asserted mid-request drops `mem_valid` immediately (asynchronous).
- Latency: `mem_ready` in cycle N gives `instr_valid` in N+1.
- A hold-only compressed instruction issues one cycle after the slot frees.
- Back-to-back: with `instr_ready` held high and `mem_ready` held high, one instruction per cycle in steady state.
- Slot outputs are stable while `instr_valid && !instr_ready`.
- No request is issued while the slot is full and not draining.

## Configuration
- `FETCH_COMPRESSED_EN` defined: full RVC alignment as above.
- Not defined:
  - `hold` logic is removed and every response word is emitted unchanged; `fpc += 4`.
  - `redirect_pc[1:0]`!=0 raises the fault path.
  - Words with `[1:0]`!=11 are emitted as-is and left to the decoder to reject.

## Structure
- Shared package `little_pkg`: `fetch_state_t` enum (FETCH, EMIT, HALT) and the `NOP`/zero-instruction constant.
- One natural sub-module: `fetch_slot`, the single-entry output register with valid/ready and a flush input driven by `redirect`.

## Test plan
- Reset with `RESET_PC`=0x100, memory always ready with word 0x00000013 → `mem_addr`=0x100, 0x104…; `instr`=0x00000013 at `pc` 0x100, 0x104, one per cycle.
- Word at 0x0 = 0x45014501 (two `c.li`) → `instr`=0x4501 at `pc` 0x0, then 0x4501 at `pc` 0x2 with no read of 0x4 in between.
- Word 0x0 = 0x00134501, word 0x4 = 0x12340000 → `c.li` at `pc` 0x0, then straddling `instr`=0x00000013 at `pc` 0x2, then `hold`=0x1234 at `pc` 0x6.
- `redirect` to 0x202 while a request to 0x8 is stalled for 3 cycles → 0x8 response discarded, next `mem_addr`=0x200, first emitted `pc`=0x202.
- `instr_ready`=0 for 5 cycles → `instr`/`pc` stable and no new `mem_valid` while the slot is full; a `redirect` in cycle 3 gives `instr_valid`=0 next cycle.
- `redirect_pc`=0x101 → `instr_fault`=1, `pc`=0x101, `instr`=0, no `mem_valid` until the next redirect. With `FETCH_COMPRESSED_EN` undefined, 0x102 also faults.

Source files
------------

// File: rtl/little_pkg.sv
// little_pkg: types and constants shared by the instruction fetch/align stage.
//   fetch_state_t : fetch FSM states (FETCH, EMIT, HALT)
//   ZERO_INSTR    : all-zero instruction word, used for reset and fault slots
//   is_full_len   : true when the low two bits mark a 32-bit instruction
package little_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EMIT  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] ZERO_INSTR = 32'h0000_0000;

    function automatic logic is_full_len(input logic [1:0] low_bits);
        return low_bits == 2'b11;
    endfunction

endpackage

// File: rtl/fetch_slot.sv
// fetch_slot: single-entry output register between the aligner and the decoder.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   flush                   drop the slot contents (redirect)
//   load                    write load_instr/load_pc/load_fault; wins over flush
//   instr_ready             decoder consumes the slot this cycle
//   instr_valid/instr/pc/instr_fault  registered slot outputs
// Slot data only changes on load, so it is stable while waiting for the decoder.
module fetch_slot
    import little_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        load_fault,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_fault
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= ZERO_INSTR;
            pc          <= RESET_PC;
            instr_fault <= 1'b0;
        end else if (load) begin
            // A fault load arrives together with flush, hence load has priority.
            instr_valid <= 1'b1;
            instr       <= load_instr;
            pc          <= load_pc;
            instr_fault <= load_fault;
        end else if (flush || instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: instruction fetch and 16/32-bit alignment stage.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   mem_valid/mem_addr              word-aligned read request
//   mem_ready/mem_rdata             request accepted, data valid same cycle
//   redirect/redirect_pc            restart fetch at a new PC (one-cycle pulse)
//   instr_valid/instr_ready         output handshake to the decoder
//   instr/pc/instr_fault            instruction, its PC, misaligned-PC fault
// Build option: define FETCH_COMPRESSED_EN for 16-bit (RVC) alignment with a
// halfword hold register; otherwise every word is emitted as-is at fpc += 4.
module fetch_aligner
    import little_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_fault
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  fpc_reg, fpc_next;
    logic         pending_reg;      // request issued but not yet accepted
    logic [31:0]  addr_reg;         // address held while pending
    logic         squash_reg;       // pending response belongs to a dead path
    logic         can_issue;
    logic         accept;
    logic         use_resp;
    logic         redirect_fault;
    logic [31:0]  fetch_addr;
    logic         slot_load;
    logic [31:0]  slot_instr;
    logic [31:0]  slot_pc;
    logic         slot_fault;

`ifdef FETCH_COMPRESSED_EN
    logic [15:0]  hold_reg, hold_next;
    logic         hold_valid_reg, hold_valid_next;
    logic         hold_step;
`endif

    // A new step may start from FETCH (slot empty) or from EMIT when the slot
    // drains this cycle; a redirect cycle never starts a new request.
    assign can_issue = !pending_reg && !redirect &&
                       ((state_reg == FETCH) || ((state_reg == EMIT) && instr_ready));

`ifdef FETCH_COMPRESSED_EN
    // A held compressed halfword is emitted without touching memory.
    assign hold_step      = can_issue && hold_valid_reg && !is_full_len(hold_reg[1:0]);
    // With a held upper half, the rest of the instruction is in the next word.
    assign fetch_addr     = {fpc_reg[31:2], 2'b00} + (hold_valid_reg ? 32'd4 : 32'd0);
    assign redirect_fault = redirect_pc[0];
    assign mem_valid      = !reset && (pending_reg || (can_issue && !hold_step));
`else
    assign fetch_addr     = {fpc_reg[31:2], 2'b00};
    assign redirect_fault = redirect_pc[1:0] != 2'b00;
    assign mem_valid      = !reset && (pending_reg || can_issue);
`endif

    assign mem_addr = !mem_valid ? 32'h0 : (pending_reg ? addr_reg : fetch_addr);
    assign accept   = mem_valid && mem_ready;
    assign use_resp = accept && !squash_reg && !redirect;

    always_comb begin
        fpc_next        = fpc_reg;
        slot_load       = 1'b0;
        slot_instr      = ZERO_INSTR;
        slot_pc         = fpc_reg;
        slot_fault      = 1'b0;
`ifdef FETCH_COMPRESSED_EN
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
`endif
        if (redirect) begin
            fpc_next = redirect_pc;
`ifdef FETCH_COMPRESSED_EN
            hold_valid_next = 1'b0;
`endif
            if (redirect_fault) begin
                slot_load  = 1'b1;
                slot_pc    = redirect_pc;
                slot_fault = 1'b1;
            end
        end else if (use_resp) begin
`ifdef FETCH_COMPRESSED_EN
            if (hold_valid_reg) begin
                // Straddling 32-bit instruction; the new upper half is held.
                slot_load  = 1'b1;
                slot_instr = {mem_rdata[15:0], hold_reg};
                hold_next  = mem_rdata[31:16];
                fpc_next   = fpc_reg + 32'd4;
            end else if (fpc_reg[1]) begin
                // Entered mid-word after a redirect: only the upper half is ours.
                hold_next       = mem_rdata[31:16];
                hold_valid_next = 1'b1;
            end else if (is_full_len(mem_rdata[1:0])) begin
                slot_load  = 1'b1;
                slot_instr = mem_rdata;
                fpc_next   = fpc_reg + 32'd4;
            end else begin
                slot_load       = 1'b1;
                slot_instr      = {16'h0000, mem_rdata[15:0]};
                hold_next       = mem_rdata[31:16];
                hold_valid_next = 1'b1;
                fpc_next        = fpc_reg + 32'd2;
            end
`else
            slot_load  = 1'b1;
            slot_instr = mem_rdata;
            fpc_next   = fpc_reg + 32'd4;
`endif
        end
`ifdef FETCH_COMPRESSED_EN
        else if (hold_step) begin
            slot_load       = 1'b1;
            slot_instr      = {16'h0000, hold_reg};
            hold_valid_next = 1'b0;
            fpc_next        = fpc_reg + 32'd2;
        end
`endif
    end

    // EMIT tracks "slot occupied next cycle"; HALT is left only by redirect.
    always_comb begin
        if (redirect) begin
            state_next = redirect_fault ? HALT : FETCH;
        end else if (state_reg == HALT) begin
            state_next = HALT;
        end else if (slot_load || (instr_valid && !instr_ready)) begin
            state_next = EMIT;
        end else begin
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= FETCH;
            fpc_reg        <= RESET_PC;
            pending_reg    <= 1'b0;
            addr_reg       <= 32'h0;
            squash_reg     <= 1'b0;
`ifdef FETCH_COMPRESSED_EN
            hold_reg       <= 16'h0000;
            hold_valid_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            fpc_reg     <= fpc_next;
            pending_reg <= mem_valid && !mem_ready;
            if (mem_valid) begin
                addr_reg <= mem_addr;
            end
            if (accept) begin
                squash_reg <= 1'b0;
            end else if (redirect && pending_reg) begin
                squash_reg <= 1'b1;
            end
`ifdef FETCH_COMPRESSED_EN
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
`endif
        end
    end

    fetch_slot #(
        .RESET_PC(RESET_PC)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .load       (slot_load),
        .load_instr (slot_instr),
        .load_pc    (slot_pc),
        .load_fault (slot_fault),
        .instr_ready(instr_ready),
        .instr_valid(instr_valid),
        .instr      (instr),
        .pc         (pc),
        .instr_fault(instr_fault)
    );

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: self-checking bench for fetch_aligner (RESET_PC = 0x100).
// The reference model walks the instruction stream from the last redirect
// target directly in a memory image; FETCH_COMPRESSED_EN selects the
// halfword-walking model to match a build with that macro defined.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_fault;

    always #5 clk = ~clk;

    logic [31:0] mem_model [64];
    assign mem_rdata = mem_model[mem_addr[7:2]];

    fetch_aligner #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .pc         (pc),
        .instr_fault(instr_fault)
    );

`ifdef FETCH_COMPRESSED_EN
    localparam logic [31:0] STALL_TGT   = 32'h0000_0202;
    localparam bit          HALF_FAULTS = 1'b0;
`else
    localparam logic [31:0] STALL_TGT   = 32'h0000_0200;
    localparam bit          HALF_FAULTS = 1'b1;
`endif

    int n_cmp  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    // reference model state
    logic [31:0] m_pc          = 32'h0000_0100;
    bit          m_fault_pend  = 1'b0;
    bit          m_fault_mode  = 1'b0;

    // previous-cycle protocol bookkeeping
    bit          p_outstanding = 1'b0;
    logic [31:0] p_addr        = 32'h0;
    bit          p_hold        = 1'b0;
    logic [31:0] p_instr       = 32'h0;
    logic [31:0] p_pc          = 32'h0;
    logic        p_if          = 1'b0;
    bit          p_redir       = 1'b0;
    bit          p_redir_bad   = 1'b0;
    logic [31:0] p_redir_pc    = 32'h0;
    bit          p_expect_iv   = 1'b0;
    bit          tb_squash     = 1'b0;

    // samples of the most recent cycle
    logic        s_mv, s_iv, s_if;
    logic [31:0] s_maddr, s_instr, s_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_model[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit bad_target(input logic [31:0] a);
`ifdef FETCH_COMPRESSED_EN
        return a[0];
`else
        return a[1:0] != 2'b00;
`endif
    endfunction

    task automatic check_transfer();
        logic [31:0] e_instr;
        logic [15:0] h0;
        logic [31:0] len;
        if (m_fault_pend) begin
            check("fault_instr", s_instr, 32'h0);
            check("fault_pc", s_pc, m_pc);
            check("fault_flag", 32'(s_if), 32'd1);
            m_fault_pend = 1'b0;
        end else if (m_fault_mode) begin
            check("halt_transfer", 32'(s_iv), 32'd0);
        end else begin
`ifdef FETCH_COMPRESSED_EN
            h0 = half_at(m_pc);
            if (h0[1:0] == 2'b11) begin
                e_instr = {half_at(m_pc + 32'd2), h0};
                len     = 32'd4;
            end else begin
                e_instr = {16'h0000, h0};
                len     = 32'd2;
            end
`else
            h0      = 16'h0;
            e_instr = mem_model[m_pc[7:2]];
            len     = 32'd4;
`endif
            check("instr", s_instr, e_instr);
            check("pc", s_pc, m_pc);
            check("fault_clear", 32'(s_if), 32'd0);
            m_pc = m_pc + len;
        end
    endtask

    // One clock cycle: drive inputs at posedge+1, sample at posedge+3,
    // check against the model, then advance to the next posedge+1.
    task automatic cycle(input bit rdy, input bit mrdy, input bit redir, input logic [31:0] rpc);
        bit was_outstanding;
        instr_ready = rdy && !redir;
        mem_ready   = mrdy;
        redirect    = redir;
        redirect_pc = rpc;
        #2;
        s_mv = mem_valid; s_maddr = mem_addr; s_iv = instr_valid;
        s_instr = instr;  s_pc = pc;          s_if = instr_fault;

        if (p_outstanding) begin
            check("req_held_valid", 32'(s_mv), 32'd1);
            check("req_held_addr", s_maddr, p_addr);
        end
        if (p_hold) begin
            check("slot_stable_valid", 32'(s_iv), 32'd1);
            check("slot_stable_instr", s_instr, p_instr);
            check("slot_stable_pc", s_pc, p_pc);
            check("slot_stable_fault", 32'(s_if), 32'(p_if));
        end
        if (p_redir) begin
            check("redirect_slot_valid", 32'(s_iv), 32'(p_redir_bad));
            if (p_redir_bad) begin
                check("redirect_fault_pc", s_pc, p_redir_pc);
                check("redirect_fault_flag", 32'(s_if), 32'd1);
            end
        end
        if (p_expect_iv) check("resp_latency", 32'(s_iv), 32'd1);
        if (s_iv && !instr_ready && !p_outstanding) check("no_req_slot_full", 32'(s_mv), 32'd0);
        if (m_fault_mode && !p_outstanding) check("halt_no_req", 32'(s_mv), 32'd0);
        if (s_mv) check("addr_align", 32'(s_maddr[1:0]), 32'd0);
        if (s_iv && instr_ready) begin
            n_xfer++;
            check_transfer();
        end

        was_outstanding = p_outstanding;
`ifdef FETCH_COMPRESSED_EN
        p_expect_iv = 1'b0;
`else
        p_expect_iv = s_mv && mrdy && !redir && !tb_squash;
`endif
        if (s_mv && mrdy) tb_squash = 1'b0;
        else if (redir && was_outstanding) tb_squash = 1'b1;
        p_outstanding = s_mv && !mrdy;
        p_addr        = s_maddr;
        p_hold        = s_iv && !instr_ready && !redir;
        p_instr = s_instr; p_pc = s_pc; p_if = s_if;
        p_redir       = redir;
        p_redir_bad   = redir && bad_target(rpc);
        p_redir_pc    = rpc;
        if (redir) begin
            m_pc         = rpc;
            m_fault_mode = bad_target(rpc);
            m_fault_pend = bad_target(rpc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          base;
        bit          redir;
        logic [31:0] rpc;
        reset = 1'b1; mem_ready = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < 64; i++) mem_model[i] = 32'h0000_0013;

        // reset values
        @(posedge clk); #1;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h100);
        check("rst_fault", 32'(instr_fault), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // first request and back-to-back streaming
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("first_req_valid", 32'(s_mv), 32'd1);
        check("first_req_addr", s_maddr, 32'h100);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("second_req_addr", s_maddr, 32'h104);
        base = n_xfer;
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("throughput", 32'(n_xfer - base), 32'd12);

        // redirect while a request is stalled: response squashed
        cycle(1'b1, 1'b0, 1'b1, 32'h8);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("stall_req_addr", s_maddr, 32'h8);
        cycle(1'b1, 1'b0, 1'b1, STALL_TGT);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("squash_accept_addr", s_maddr, 32'h8);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("post_squash_addr", s_maddr, 32'h200);
        check("squash_discard", 32'(s_iv), 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // decoder stall with a redirect in the third stalled cycle
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_valid_held", 32'(s_iv), 32'd1);
        check("stall_no_req", 32'(s_mv), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 32'h40);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("flush_valid", 32'(s_iv), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // misaligned redirect targets
        cycle(1'b1, 1'b1, 1'b1, 32'h101);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("odd_fault_flag", 32'(s_if), 32'd1);
        check("odd_fault_pc", s_pc, 32'h101);
        check("odd_fault_instr", s_instr, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("halt_idle", 32'(s_mv), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'h102);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("half_fault_flag", 32'(s_if), 32'(HALF_FAULTS));

        // compressed and straddling words
        mem_model[0] = 32'h0013_4501;
        mem_model[1] = 32'h1234_0000;
        cycle(1'b1, 1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        mem_model[0] = 32'h4501_4501;
        cycle(1'b1, 1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        cycle(1'b1, 1'b1, 1'b1, 32'h0);
        for (int n = 0; n < 400; n++) begin
            redir = ($urandom_range(0, 19) == 0);
            rpc   = $urandom & 32'hFF;
            if ($urandom_range(0, 5) != 0) begin
`ifdef FETCH_COMPRESSED_EN
                rpc[0] = 1'b0;
`else
                rpc[1:0] = 2'b00;
`endif
            end
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, redir, rpc);
        end

        // asynchronous reset in the middle of a stalled request
        cycle(1'b1, 1'b0, 1'b1, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_reset_req", 32'(s_mv), 32'd1);
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_mem_valid", 32'(mem_valid), 32'd0);
        check("async_rst_mem_addr", mem_addr, 32'h0);
        check("async_rst_instr_valid", 32'(instr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
